// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - divided-clock period/high-phase checker with lock and timeout
module clk_div_monitor #(
  parameter int RATIO_WIDTH = 8,
  parameter int CNT_WIDTH   = 10,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [RATIO_WIDTH-1:0] i_div_ratio,
  input  logic                   i_div_clk,
  output logic [CNT_WIDTH-1:0]   o_period,
  output logic [CNT_WIDTH-1:0]   o_high,
  output logic                   o_valid,
  output logic                   o_err,
  output logic                   o_timeout,
  output logic                   o_locked
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_MEASURE} state_t;

  state_t                 state;
  logic                   d1, d2;
  logic [RATIO_WIDTH-1:0] r_ratio;
  logic [CNT_WIDTH-1:0]   per_cnt, hi_cnt;
  logic [GW-1:0]          good_cnt;

  logic                 rise, abort, start_ok, per_ok, hi_ok, timed_out;
  logic [CNT_WIDTH-1:0] r_ext, half_lo, half_hi, limit, per_inc, hi_inc;
  logic [GW-1:0]        good_nxt;

  assign rise      = d1 & ~d2;
  assign abort     = (i_div_ratio != r_ratio) | ~i_en;
  assign start_ok  = i_div_ratio >= RATIO_WIDTH'(2);
  assign r_ext     = CNT_WIDTH'(r_ratio);
  assign half_lo   = r_ext >> 1;
  assign half_hi   = (r_ext + CNT_WIDTH'(1)) >> 1;
  assign limit     = (r_ext << 1) + CNT_WIDTH'(2);
  assign per_ok    = per_cnt == r_ext;
  assign hi_ok     = (hi_cnt == half_lo) || (hi_cnt == half_hi);
  assign timed_out = per_cnt >= limit;
  assign per_inc   = (&per_cnt) ? per_cnt : per_cnt + CNT_WIDTH'(1);
  assign hi_inc    = (d1 && !(&hi_cnt)) ? hi_cnt + CNT_WIDTH'(1) : hi_cnt;
  assign good_nxt  = (good_cnt == GW'(LOCK_COUNT)) ? good_cnt : good_cnt + GW'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      d1        <= 1'b0;
      d2        <= 1'b0;
      r_ratio   <= '0;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      good_cnt  <= '0;
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
      o_locked  <= 1'b0;
    end else begin
      d1      <= i_div_clk;
      d2      <= d1;
      r_ratio <= i_div_ratio;
      o_valid <= 1'b0;
      // A new ratio or disable outranks any rise or timeout this cycle
      if (abort) begin
        state     <= S_IDLE;
        per_cnt   <= '0;
        hi_cnt    <= '0;
        good_cnt  <= '0;
        o_err     <= 1'b0;
        o_timeout <= 1'b0;
        o_locked  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            per_cnt  <= '0;
            hi_cnt   <= '0;
            o_locked <= 1'b0;
            if (start_ok) state <= S_ALIGN;
          end
          S_ALIGN: begin
            if (rise) begin
              // The rise cycle is the first cycle of the first measured period
              per_cnt  <= CNT_WIDTH'(1);
              hi_cnt   <= CNT_WIDTH'(1);
              good_cnt <= '0;
              state    <= S_MEASURE;
            end else if (timed_out) begin
              o_timeout <= 1'b1;
              o_err     <= 1'b1;
              per_cnt   <= '0;
              hi_cnt    <= '0;
            end else begin
              per_cnt <= per_inc;
            end
          end
          S_MEASURE: begin
            if (rise) begin
              o_period <= per_cnt;
              o_high   <= hi_cnt;
              o_valid  <= 1'b1;
              per_cnt  <= CNT_WIDTH'(1);
              hi_cnt   <= CNT_WIDTH'(1);
              if (per_ok && hi_ok) begin
                good_cnt <= good_nxt;
                o_locked <= good_nxt == GW'(LOCK_COUNT);
              end else begin
                o_err    <= 1'b1;
                good_cnt <= '0;
                o_locked <= 1'b0;
              end
            end else if (timed_out) begin
              o_timeout <= 1'b1;
              o_err     <= 1'b1;
              per_cnt   <= '0;
              hi_cnt    <= '0;
              state     <= S_ALIGN;
            end else begin
              per_cnt <= per_inc;
              hi_cnt  <= hi_inc;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - scoreboard bench for clk_div_monitor
module tb_clk_div_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] ratio = 8'd0;
  logic       div_clk = 1'b0;
  logic [9:0] period, high;
  logic       valid, err, timeout, locked;

  clk_div_monitor #(.RATIO_WIDTH(8), .CNT_WIDTH(10), .LOCK_COUNT(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_div_ratio (ratio),
    .i_div_clk   (div_clk),
    .o_period    (period),
    .o_high      (high),
    .o_valid     (valid),
    .o_err       (err),
    .o_timeout   (timeout),
    .o_locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int per;
    int hi_lo;
    int hi_hi;
    bit lock;
    bit err;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_valid = 0;

  int div_period = 4;
  int div_high = 2;
  bit div_run = 1'b0;
  int dcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference divider, driven away from the sampling edge
  always @(negedge clk) begin
    if (!div_run) begin
      div_clk = 1'b0;
      dcnt = 0;
    end else begin
      div_clk = (dcnt < div_high);
      dcnt = (dcnt + 1 >= div_period) ? 0 : dcnt + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_valid: got period=%0d high=%0d expected no output (t=%0t)",
                 period, high, $time);
      end else begin
        e = sb.pop_front();
        check("period", int'(period), e.per);
        n_vec++;
        if (int'(high) != e.hi_lo && int'(high) != e.hi_hi) begin
          n_bad++;
          $display("FAIL high: got %0d expected %0d or %0d (t=%0t)", high, e.hi_lo, e.hi_hi, $time);
        end
        check("locked_at_valid", int'(locked), int'(e.lock));
        check("err_at_valid", int'(err), int'(e.err));
        if (e.gap > 0) check("valid_spacing", cyc - last_valid, e.gap);
      end
      last_valid = cyc;
    end
  end

  task automatic set_cfg(input int r, input int dp, input int dh, input bit run);
    ratio = 8'(r);
    div_period = dp;
    div_high = dh;
    div_run = run;
  endtask

  task automatic push_run(input int n, input int per, input int hlo, input int hhi, input bit e_err);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.per = per;
      e.hi_lo = hlo;
      e.hi_hi = hhi;
      e.lock = !e_err && (i >= 3);
      e.err = e_err;
      e.gap = (i == 0) ? 0 : per;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string name, input int limit);
    int k;
    k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_drain: got %0d pending outputs expected 0 within %0d cycles", name, sb.size(), limit);
      sb.delete();
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    wait_cycles(3);
    check("rst_valid", int'(valid), 0);
    check("rst_period", int'(period), 0);
    check("rst_err", int'(err), 0);
    check("rst_locked", int'(locked), 0);

    // R=4 with a correct divider
    set_cfg(4, 4, 2, 1'b1);
    en = 1'b1;
    rst = 1'b0;
    push_run(6, 4, 2, 2, 1'b0);
    drain("r4", 120);
    check("r4_locked", int'(locked), 1);
    check("r4_err", int'(err), 0);

    // Ratio sweep without reset; each step must drop lock then re-lock
    for (int r = 2; r <= 9; r++) begin
      set_cfg(r, r, (r + 1) / 2, 1'b1);
      wait_cycles(2);
      check("sweep_lock_cleared", int'(locked), 0);
      push_run(5, r, r / 2, (r + 1) / 2, 1'b0);
      drain("sweep", 200);
      check("sweep_locked", int'(locked), 1);
      check("sweep_err", int'(err), 0);
    end

    // Divider running at 6 while programmed for 5
    set_cfg(5, 6, 3, 1'b1);
    push_run(3, 6, 3, 3, 1'b1);
    drain("mismatch", 120);
    check("mismatch_err", int'(err), 1);
    check("mismatch_locked", int'(locked), 0);

    // Stalled divider at R=3: timeout after 2R+2 cycles in ALIGN
    set_cfg(3, 3, 1, 1'b0);
    wait_cycles(2);
    check("ratio_chg_clears_err", int'(err), 0);
    wait_cycles(4);
    check("timeout_not_early", int'(timeout), 0);
    wait_cycles(8);
    check("timeout_set", int'(timeout), 1);
    check("timeout_err", int'(err), 1);
    check("timeout_locked", int'(locked), 0);

    // Bypass ratio and disable: no output, no flags
    set_cfg(1, 2, 1, 1'b1);
    wait_cycles(30);
    check("bypass_err", int'(err), 0);
    check("bypass_timeout", int'(timeout), 0);
    check("bypass_locked", int'(locked), 0);
    en = 1'b0;
    set_cfg(4, 4, 2, 1'b1);
    wait_cycles(30);
    check("disabled_err", int'(err), 0);
    check("disabled_locked", int'(locked), 0);

    // Lock at R=6, then reset mid-period
    en = 1'b1;
    set_cfg(6, 6, 3, 1'b1);
    push_run(4, 6, 3, 3, 1'b0);
    drain("r6", 120);
    check("r6_locked", int'(locked), 1);
    wait_cycles(2);
    #2 rst = 1'b1;
    #1;
    check("midrst_period", int'(period), 0);
    check("midrst_high", int'(high), 0);
    check("midrst_locked", int'(locked), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_valid", int'(valid), 0);
    @(negedge clk);
    rst = 1'b0;
    push_run(4, 6, 3, 3, 1'b0);
    drain("r6_relock", 120);
    check("r6_relocked", int'(locked), 1);
    set_cfg(6, 6, 3, 1'b0);
    en = 1'b0;
    wait_cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
